// File: rtl/CamCapturePkg.sv
`timescale 1ns/1ps
// CamCapturePkg: shared definitions for the camera pixel capture block.
// Holds the capture FSM state type and the output word layout constants.
package CamCapturePkg;

  // Bit position of the frame-start marker in a queue word.
  localparam int MARKER_BIT = 16;

  // Width of one assembled RGB565 pixel.
  localparam int PIXEL_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    ACTIVE,
    DROP
  } cap_state_t;

endpackage

// File: rtl/cam_byte_pairer.sv
`timescale 1ns/1ps
// cam_byte_pairer: tracks the byte phase within a camera line and assembles
// two consecutive bytes (high byte first) into one RGB565 pixel. The phase
// restarts at every href rising edge, so a stray byte left over from a previous
// line can never be paired with the first byte of the next one.
module cam_byte_pairer
  import CamCapturePkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               href,
  input  logic               href_prev,
  input  logic [7:0]         data,
  output logic               pixel_valid,
  output logic [PIXEL_W-1:0] pixel,
  output logic               odd_pending
);

  logic       phase;
  logic [7:0] high_byte;
  logic       href_rise;
  logic       eff_phase;

  assign href_rise   = href && !href_prev;
  assign eff_phase   = href_rise ? 1'b0 : phase;
  assign pixel_valid = enable && href && eff_phase;
  assign pixel       = {high_byte, data};
  assign odd_pending = phase;

  // Latch the even byte and toggle the phase on every byte while href is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase     <= 1'b0;
      high_byte <= 8'h00;
    end else if (!enable) begin
      phase <= 1'b0;
    end else if (href) begin
      if (!eff_phase) begin
        high_byte <= data;
        phase     <= 1'b1;
      end else begin
        phase <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cam_pixel_capture.sv
`timescale 1ns/1ps
// cam_pixel_capture: captures RGB565 frames from a parallel camera bus and
// writes one 17-bit word per pixel into a downstream queue (bit 16 marks the
// first pixel of a frame). Geometry violations and queue overflows set a
// per-frame sticky error; an overflow abandons the rest of the frame.
// Optional build macro CAM_CAPTURE_STATS_EN adds frame_count and drop_count.
module cam_pixel_capture
  import CamCapturePkg::*;
#(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                vsync,
  input  logic                href,
  input  logic [7:0]          cam_data,
  input  logic                queue_full,
  output logic [MARKER_BIT:0] queue_data,
  output logic                queue_wr_en,
  output logic                frame_done,
  output logic                frame_error
`ifdef CAM_CAPTURE_STATS_EN
  ,
  output logic [15:0]         frame_count,
  output logic [15:0]         drop_count
`endif
);

  localparam int COL_W = $clog2(FRAME_WIDTH + 1);
  localparam int ROW_W = $clog2(FRAME_HEIGHT + 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(FRAME_WIDTH);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(FRAME_HEIGHT);

  logic               vsync_r, vsync_q;
  logic               href_r, href_q;
  logic [7:0]         data_r;
  cap_state_t         state, state_next;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;

  logic               pair_enable;
  logic               pixel_valid;
  logic [PIXEL_W-1:0] pixel;
  logic               odd_pending;

  logic               vsync_rise, vsync_fall, href_fall;
  logic               line_end, line_bad, in_bounds;
  logic               start_frame, end_frame;
  logic               do_write, do_drop, out_of_bounds;
  logic               err_set;

  assign vsync_rise  = vsync_r && !vsync_q;
  assign vsync_fall  = !vsync_r && vsync_q;
  assign href_fall   = href_q && !href_r;
  assign pair_enable = (state == ACTIVE) || (state == DROP);
  assign line_end    = (state == ACTIVE) && href_fall;
  assign line_bad    = odd_pending || (col != COL_MAX) || (row >= ROW_MAX);
  assign in_bounds   = (col < COL_MAX) && (row < ROW_MAX);
  assign err_set     = do_drop || out_of_bounds || (line_end && line_bad) ||
                       ((state == ACTIVE) && end_frame && (row != ROW_MAX));

  // Register the camera inputs once, plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_r <= 1'b0;
      vsync_q <= 1'b0;
      href_r  <= 1'b0;
      href_q  <= 1'b0;
      data_r  <= 8'h00;
    end else begin
      vsync_r <= vsync;
      vsync_q <= vsync_r;
      href_r  <= href;
      href_q  <= href_r;
      data_r  <= cam_data;
    end
  end

  cam_byte_pairer u_pairer (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (pair_enable),
    .href        (href_r),
    .href_prev   (href_q),
    .data        (data_r),
    .pixel_valid (pixel_valid),
    .pixel       (pixel),
    .odd_pending (odd_pending)
  );

  // Capture FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and per-pixel write/drop decisions.
  always_comb begin
    state_next    = state;
    start_frame   = 1'b0;
    end_frame     = 1'b0;
    do_write      = 1'b0;
    do_drop       = 1'b0;
    out_of_bounds = 1'b0;
    case (state)
      IDLE: begin
        if (vsync_r) state_next = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (vsync_fall) begin
          state_next  = ACTIVE;
          start_frame = 1'b1;
        end
      end
      ACTIVE: begin
        if (vsync_rise) begin
          state_next = WAIT_FRAME;
          end_frame  = 1'b1;
        end else if (pixel_valid) begin
          if (!in_bounds) begin
            out_of_bounds = 1'b1;
          end else if (queue_full) begin
            do_drop    = 1'b1;
            state_next = DROP;
          end else begin
            do_write = 1'b1;
          end
        end
      end
      DROP: begin
        if (vsync_rise) begin
          state_next = WAIT_FRAME;
          end_frame  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Saturating column/row counters; columns restart at each line end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col <= '0;
      row <= '0;
    end else if (start_frame) begin
      col <= '0;
      row <= '0;
    end else if (state == ACTIVE) begin
      if (line_end) begin
        col <= '0;
        if (row != ROW_MAX) row <= row + 1'b1;
      end else if (pixel_valid && (col != COL_MAX)) begin
        col <= col + 1'b1;
      end
    end
  end

  // Queue write port, frame-done pulse and per-frame sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      queue_data  <= '0;
      queue_wr_en <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      queue_wr_en <= do_write;
      frame_done  <= end_frame;
      if (do_write) queue_data <= {(row == '0) && (col == '0), pixel};
      if (start_frame) begin
        frame_error <= 1'b0;
      end else if (err_set) begin
        frame_error <= 1'b1;
      end
    end
  end

`ifdef CAM_CAPTURE_STATS_EN
  // Frame counter wraps; drop counter saturates and counts every lost pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= 16'h0000;
      drop_count  <= 16'h0000;
    end else begin
      if (end_frame) frame_count <= frame_count + 16'h0001;
      if ((do_drop || ((state == DROP) && pixel_valid)) && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'h0001;
    end
  end
`endif

endmodule
